// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: the FSM state encoding and the
// elaboration-time parameter check.
// Ports: none (package).
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A legal configuration needs non-empty operands and chunks that exactly
    // tile the operand width.
    function automatic bit params_ok(input int width, input int chunk);
        return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of the serial adder, bundled in one interface.
// Ports (signals):
//   in_valid/in_ready     operand handshake
//   a, b, cin, sub        operands and mode
//   out_valid/out_ready   result handshake
//   sum, cout, ovf        result
// Modports: master = producer/consumer side, slave = the adder.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_slice.sv
// Combinational ripple of CHUNK full-adder cells.
// Ports:
//   a, b   in  CHUNK  operand chunks
//   ci     in  1      carry into bit 0
//   s      out CHUNK  chunk sum
//   co     out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (for signed overflow)
module adder_slice #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle two's-complement adder/subtractor. Adds CHUNK bits per clock
// through adder_slice, keeping the inter-chunk carry in a flip-flop.
// Subtraction is a + ~b + 1: b is inverted at accept and the carry seeded to 1.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  synchronous active-low reset
//   bus    serial_adder_if.slave (operand and result handshakes)
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | adding chunk k each cycle
// DONE  | result held until out_ready
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
        $error("serial_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    state_t           state;
    logic [KW-1:0]    k;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_msb;

    assign slice_a = op_a[int'(k)*CHUNK +: CHUNK];
    assign slice_b = op_b[int'(k)*CHUNK +: CHUNK];

    adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .ci    (carry),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            k      <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.a;
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? 1'b1 : bus.cin;
                        k     <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sum_r[int'(k)*CHUNK +: CHUNK] <= slice_s;
                    carry <= slice_co;
                    if (k == K_LAST) begin
                        // The last chunk holds the MSB, so its carries give cout/ovf.
                        cout_r <= slice_co;
                        ovf_r  <= slice_co ^ slice_c_msb;
                        k      <= '0;
                        state  <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rst_n is the only combinational input-to-output path.
    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: three instances (8/2, 8/8, 16/4) share
// one set of stimulus variables; only the selected instance sees in_valid and
// out_ready. Results are compared against a plain-arithmetic signed/unsigned
// reference.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int          sel;
    logic        tb_in_valid;
    logic [15:0] tb_a;
    logic [15:0] tb_b;
    logic        tb_cin;
    logic        tb_sub;
    logic        tb_out_ready;

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [15:0] obs_sum;
    logic        obs_cout;
    logic        obs_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    serial_adder_if #(.WIDTH(8))  if0 ();
    serial_adder_if #(.WIDTH(8))  if1 ();
    serial_adder_if #(.WIDTH(16)) if2 ();

    assign if0.in_valid  = (sel == 0) && tb_in_valid;
    assign if0.a         = tb_a[7:0];
    assign if0.b         = tb_b[7:0];
    assign if0.cin       = tb_cin;
    assign if0.sub       = tb_sub;
    assign if0.out_ready = (sel == 0) && tb_out_ready;

    assign if1.in_valid  = (sel == 1) && tb_in_valid;
    assign if1.a         = tb_a[7:0];
    assign if1.b         = tb_b[7:0];
    assign if1.cin       = tb_cin;
    assign if1.sub       = tb_sub;
    assign if1.out_ready = (sel == 1) && tb_out_ready;

    assign if2.in_valid  = (sel == 2) && tb_in_valid;
    assign if2.a         = tb_a;
    assign if2.b         = tb_b;
    assign if2.cin       = tb_cin;
    assign if2.sub       = tb_sub;
    assign if2.out_ready = (sel == 2) && tb_out_ready;

    serial_adder #(.WIDTH(8),  .CHUNK(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    serial_adder #(.WIDTH(8),  .CHUNK(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_adder #(.WIDTH(16), .CHUNK(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always_comb begin
        obs_in_ready  = 1'b0;
        obs_out_valid = 1'b0;
        obs_sum       = '0;
        obs_cout      = 1'b0;
        obs_ovf       = 1'b0;
        case (sel)
            0: begin
                obs_in_ready = if0.in_ready; obs_out_valid = if0.out_valid;
                obs_sum = {8'h00, if0.sum}; obs_cout = if0.cout; obs_ovf = if0.ovf;
            end
            1: begin
                obs_in_ready = if1.in_ready; obs_out_valid = if1.out_valid;
                obs_sum = {8'h00, if1.sum}; obs_cout = if1.cout; obs_ovf = if1.ovf;
            end
            default: begin
                obs_in_ready = if2.in_ready; obs_out_valid = if2.out_valid;
                obs_sum = if2.sum; obs_cout = if2.cout; obs_ovf = if2.ovf;
            end
        endcase
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (sel=%0d, t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 2) ? 16 : 8;
    endfunction

    function automatic int nch_of(input int s);
        return (s == 1) ? 1 : 4;
    endfunction

    // Reference: unsigned sum for result/carry, true signed value for overflow.
    task automatic ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub,
                             output longint e_sum, output longint e_cout, output longint e_ovf);
        longint mask, ua, ub, full, sa, sb, t, lo, hi;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = sub ? ua + ((~ub) & mask) + 1 : ua + ub + longint'(cin);
        e_sum  = full & mask;
        e_cout = (full >> w) & 1;
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        t  = sub ? sa - sb : sa + sb + longint'(cin);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        e_ovf = ((t < lo) || (t > hi)) ? 1 : 0;
    endtask

    // One full transaction on the selected instance. hold > 0 keeps out_ready
    // low for that many DONE cycles while pulsing in_valid with junk operands.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input longint e_sum, input longint e_cout,
                          input longint e_ovf, input int hold);
        int lat;
        logic [15:0] h_sum;
        logic h_cout, h_ovf;
        @(negedge clk);
        tb_a = a; tb_b = b; tb_cin = cin; tb_sub = sub; tb_in_valid = 1'b1;
        check("in_ready_idle", obs_in_ready, 1);
        @(posedge clk);
        #1;
        tb_in_valid = 1'b0;
        tb_a = $urandom(); tb_b = $urandom(); tb_cin = $urandom_range(0, 1); tb_sub = $urandom_range(0, 1);
        lat = 0;
        while (!obs_out_valid && lat < 20) begin
            check("busy_in_ready", obs_in_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid", obs_out_valid, 1);
        check("latency", lat, nch_of(sel));
        check("sum", obs_sum, e_sum);
        check("cout", obs_cout, e_cout);
        check("ovf", obs_ovf, e_ovf);
        h_sum = obs_sum; h_cout = obs_cout; h_ovf = obs_ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            tb_in_valid = 1'b1;
            tb_a = $urandom(); tb_b = $urandom(); tb_cin = $urandom_range(0, 1); tb_sub = $urandom_range(0, 1);
            @(posedge clk);
            #1;
            tb_in_valid = 1'b0;
            check("hold_valid", obs_out_valid, 1);
            check("hold_ready", obs_in_ready, 0);
            check("hold_sum", obs_sum, longint'(h_sum));
            check("hold_flags", {h_cout, h_ovf} == {obs_cout, obs_ovf}, 1);
        end
        @(negedge clk);
        tb_out_ready = 1'b1;
        @(posedge clk);
        #1;
        tb_out_ready = 1'b0;
        check("consumed_valid", obs_out_valid, 0);
        check("consumed_in_ready", obs_in_ready, 1);
    endtask

    task automatic run_random(input int s, input int n);
        logic [15:0] a, b;
        logic cin, sub;
        longint es, ec, eo;
        sel = s;
        for (int i = 0; i < n; i++) begin
            a = 16'($urandom()); b = 16'($urandom());
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            if (width_of(s) == 8) begin
                a[15:8] = 8'h00; b[15:8] = 8'h00;
            end
            ref_model(width_of(s), a, b, cin, sub, es, ec, eo);
            run_op(a, b, cin, sub, es, ec, eo, 0);
        end
    endtask

    initial begin
        sel = 0;
        tb_in_valid = 1'b0; tb_out_ready = 1'b0;
        tb_a = '0; tb_b = '0; tb_cin = 1'b0; tb_sub = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", obs_in_ready, 0);
        check("rst_out_valid", obs_out_valid, 0);
        check("rst_sum", obs_sum, 0);
        check("rst_flags", {obs_cout, obs_ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", obs_in_ready, 1);

        // Directed 8/2 cases with hand-derived results.
        run_op(16'h0F, 16'h01, 1'b0, 1'b0, 'h10, 0, 0, 0);
        run_op(16'hFF, 16'h01, 1'b1, 1'b0, 'h01, 1, 0, 0);
        run_op(16'h7F, 16'h01, 1'b0, 1'b0, 'h80, 0, 1, 0);
        run_op(16'h05, 16'h07, 1'b0, 1'b1, 'hFE, 0, 0, 0);
        run_op(16'h05, 16'h07, 1'b1, 1'b1, 'hFE, 0, 0, 0);
        run_op(16'h80, 16'h01, 1'b0, 1'b1, 'h7F, 1, 1, 0);
        run_op(16'h80, 16'h01, 1'b1, 1'b1, 'h7F, 1, 1, 0);

        // Backpressure: hold 5 DONE cycles, then a normal follow-up op.
        run_op(16'h3C, 16'h55, 1'b1, 1'b0, 'h92, 0, 1, 5);
        run_op(16'h12, 16'h34, 1'b0, 1'b0, 'h46, 0, 0, 0);

        // Reset on the 2nd BUSY cycle discards the operation.
        @(negedge clk);
        tb_a = 16'hAA; tb_b = 16'h0F; tb_cin = 1'b0; tb_sub = 1'b0; tb_in_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", obs_in_ready, 0);
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", obs_out_valid, 0);
        check("mid_rst_sum", obs_sum, 0);
        check("mid_rst_cout", obs_cout, 0);
        check("mid_rst_ovf", obs_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", obs_in_ready, 1);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("no_stale_valid", obs_out_valid, 0);
        end
        run_op(16'h10, 16'h20, 1'b0, 1'b0, 'h30, 0, 0, 0);

        // Random sweeps across all three configurations.
        run_random(0, 200);
        run_random(1, 1000);
        run_random(2, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
